// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared width, state and counter definitions for seq_divider
package seq_divider_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice this.
    localparam int N_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_e;

    // Step counter width: clog2(n), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int N = 6
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] div_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Shift in the next dividend bit and trial-subtract; the N+1-bit difference
    // cannot wrap because the partial remainder is always below the divisor.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, div_i};
        q_o     = ~diff[N];
        rem_o   = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - shift-subtract divider, 2N/N -> N quotient + N remainder; SEQ_DIVIDER_SIGNED_EN selects two's complement operands
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [N-1:0]  Q_POS_LIM = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  Q_NEG_LIM = {1'b1, {(N-1){1'b0}}};
`endif

    state_e         state_q;
    logic [2*N-1:0] dvd_q;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   dmag_q;
    logic [N-1:0]   pr_q;
    logic [N-1:0]   lo_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;
    logic           busy_q;
    logic           done_q;
    logic           dz_q;
    logic           ovf_q;

    logic           dvd_neg;
    logic           dvs_neg;
    logic [2*N-1:0] dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic           q_neg;
    logic           fix_ovf;
    logic [N-1:0]   q_fix_d;
    logic [N-1:0]   r_fix_d;
    logic [N-1:0]   step_rem;
    logic           step_q;

    // Operand magnitudes and the final sign correction / range check.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_neg = dvd_q[2*N-1];
        dvs_neg = dvs_q[N-1];
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`endif
        dvd_mag = dvd_neg ? -dvd_q : dvd_q;
        dvs_mag = dvs_neg ? -dvs_q : dvs_q;
        q_neg   = dvd_neg ^ dvs_neg;
`ifdef SEQ_DIVIDER_SIGNED_EN
        fix_ovf = q_neg ? (lo_q > Q_NEG_LIM) : (lo_q > Q_POS_LIM);
`else
        fix_ovf = 1'b0;
`endif
        q_fix_d = q_neg ? -lo_q : lo_q;
        r_fix_d = dvd_neg ? -pr_q : pr_q;
    end

    div_step #(.N(N)) u_step (
        .rem_i (pr_q),
        .bit_i (lo_q[N-1]),
        .div_i (dmag_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Control FSM with registered results; lo_q doubles as dividend low half and quotient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dmag_q      <= '0;
            pr_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        dz_q    <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (dvs_q == '0) begin
                        dz_q        <= 1'b1;
                        quotient_q  <= '1;
                        remainder_q <= dvd_q[N-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
                        ovf_q       <= 1'b1;
                        quotient_q  <= '0;
                        remainder_q <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        pr_q    <= dvd_mag[2*N-1:N];
                        lo_q    <= dvd_mag[N-1:0];
                        dmag_q  <= dvs_mag;
                        cnt_q   <= '0;
                        state_q <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    pr_q  <= step_rem;
                    lo_q  <= {lo_q[N-2:0], step_q};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (fix_ovf) begin
                        ovf_q       <= 1'b1;
                        quotient_q  <= '0;
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= q_fix_d;
                        remainder_q <= r_fix_d;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (unsigned or SEQ_DIVIDER_SIGNED_EN build)
module tb_seq_divider;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic           overflow;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2*N-1:0] dvd;
        logic [N-1:0]   dvs;
        exp_t           e;
    } vec_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input int q, input int r, input bit dz, input bit ov, input int lat);
        exp_t e;
        e.q = q[N-1:0]; e.r = r[N-1:0]; e.dz = dz; e.ov = ov; e.lat = lat;
        return e;
    endfunction

    // Reference: plain integer division on the operand values.
    function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        int sd, sv, am, bm, qm, rm;
        bit neg;
        if (dvs == 0) return mk(-1, int'(dvd[N-1:0]), 1, 0, 2);
`ifdef SEQ_DIVIDER_SIGNED_EN
        sd = int'($signed(dvd));
        sv = int'($signed(dvs));
`else
        sd = int'(dvd);
        sv = int'(dvs);
`endif
        am = (sd < 0) ? -sd : sd;
        bm = (sv < 0) ? -sv : sv;
        if (am >= bm * (1 << N)) return mk(0, 0, 0, 1, 2);
        qm  = am / bm;
        rm  = am % bm;
        neg = (sd < 0) != (sv < 0);
        if (neg ? (qm > (1 << (N-1))) : (qm > (1 << (N-1)) - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            return mk(0, 0, 0, 1, N + 3);
`endif
        end
        return mk(neg ? -qm : qm, (sd < 0) ? -rm : rm, 0, 0, N + 3);
    endfunction

    task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          input exp_t e, input bit repulse, input string tag);
        exp_t ex;
        int   lat = 0;
        bit   busy_bad = 0;
        sb_q.push_back(e);
        dividend = dvd;
        divisor  = dvs;
        load     = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (repulse && c == 4) begin load = 1'b1; dividend = 12'h0FF; divisor = 6'd3; end
            if (repulse && c == 5) load = 1'b0;
            if (done) begin
                lat = c;
                if (busy) busy_bad = 1;
            end else if (!busy) begin
                busy_bad = 1;
            end
        end
        load = 1'b0;
        ex = sb_q.pop_front();
        if (lat == 0) begin
            check($sformatf("%s timeout", tag), 0, 1);
        end else begin
            check($sformatf("%s quotient", tag), quotient, ex.q);
            check($sformatf("%s remainder", tag), remainder, ex.r);
            check($sformatf("%s div_by_zero", tag), div_by_zero, ex.dz);
            check($sformatf("%s overflow", tag), overflow, ex.ov);
            check($sformatf("%s latency", tag), lat, ex.lat);
            check($sformatf("%s busy_window", tag), busy_bad, 0);
            @(posedge clk); #1;
            check($sformatf("%s done_pulse", tag), done, 0);
            check($sformatf("%s held", tag), {quotient, remainder}, {ex.q, ex.r});
        end
    endtask

    vec_t vecs[$];

    initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back('{12'hF9C, 6'd7,  mk(6'b110010, 6'b111110, 0, 0, 9)});
        vecs.push_back('{12'd224, 6'd7,  mk(0, 0, 0, 1, 9)});
        vecs.push_back('{12'hF20, 6'd7,  mk(6'b100000, 0, 0, 0, 9)});
        vecs.push_back('{12'hFBF, 6'd5,  mk(6'h33, 0, 0, 0, 9)});
        vecs.push_back('{12'h0A5, 6'd0,  mk(6'h3F, 6'h25, 1, 0, 2)});
        vecs.push_back('{12'd100, 6'h39, mk(6'h32, 2, 0, 0, 9)});
        vecs.push_back('{12'hF9C, 6'h39, mk(14, 6'h3E, 0, 0, 9)});
        vecs.push_back('{12'h800, 6'h20, mk(0, 0, 0, 1, 2)});
        vecs.push_back('{12'd217, 6'd7,  mk(31, 0, 0, 0, 9)});
`else
        vecs.push_back('{12'd100,  6'd7,  mk(14, 2, 0, 0, 9)});
        vecs.push_back('{12'h0A5,  6'd0,  mk(6'h3F, 6'h25, 1, 0, 2)});
        vecs.push_back('{12'd448,  6'd7,  mk(0, 0, 0, 1, 2)});
        vecs.push_back('{12'd0,    6'd5,  mk(0, 0, 0, 0, 9)});
        vecs.push_back('{12'd4095, 6'd63, mk(0, 0, 0, 1, 2)});
        vecs.push_back('{12'd4031, 6'd63, mk(63, 62, 0, 0, 9)});
        vecs.push_back('{12'd63,   6'd1,  mk(63, 0, 0, 0, 9)});
        vecs.push_back('{12'd64,   6'd1,  mk(0, 0, 0, 1, 2)});
        vecs.push_back('{12'd13,   6'd13, mk(1, 0, 0, 0, 9)});
`endif

        reset = 1'b0; load = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].e, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            logic [N-1:0]   rs;
            logic [2*N-1:0] rd;
            rs = N'($urandom_range(0, (1 << N) - 1));
            rd = (i % 4 == 0 || rs == 0) ? (2*N)'($urandom_range(0, (1 << 2*N) - 1))
                                         : (2*N)'($urandom_range(0, int'(rs) * 64 - 1));
            run_op(rd, rs, model(rd, rs), 0, $sformatf("rand%0d", i));
        end

        run_op(12'd100, 6'd7, mk(14, 2, 0, 0, 9), 1, "repulse");
        repeat (10) begin
            @(posedge clk); #1;
            if (done) check("repulse_extra_done", done, 0);
        end
        check("repulse_idle", {busy, done}, 0);

        dividend = 12'd100; divisor = 6'd7; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("reset_mid_iter", {quotient, remainder, busy, done, div_by_zero, overflow}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {busy, done}, 0);
        run_op(12'd100, 6'd7, model(12'd100, 6'd7), 0, "after_reset");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
